ext_bus_target: RTL and testbench
=================================

EXT_BUS_TARGET -- requirements
Module: ext_bus_target

Interface
REQ-001 Parameter BASE_ADDR, default 16'hFF00: block selected when ADDR[15:2] == BASE_ADDR[15:2].
REQ-002 Parameter FIFO_DEPTH, default 4: bus-to-local FIFO entries; power of two, 2..16.
REQ-003 CLK  in  1  board clock; single clock domain.
REQ-004 RESET  in  1  reset, asynchronous, active-high.
REQ-005 ADDR  in  16  bus address; ADDR[1:0] selects register.
REQ-006 RDN  in  1  active-low read strobe.
REQ-007 WR0N  in  1  active-low write strobe, byte lane [7:0].
REQ-008 WR1N  in  1  active-low write strobe, byte lane [15:8].
REQ-009 DBUS_IN  in  16  bus write data.
REQ-010 DBUS_OUT  out  16  bus read data.
REQ-011 DBUS_OE  out  1  high while block drives read data.
REQ-012 INT  out  1  active-high interrupt request, routable to an INTn pin.
REQ-013 RX_DATA  out  16; RX_VALID  out  1; RX_READY  in  1: local FIFO drain port.
REQ-014 TX_DATA  in  16; TX_LOAD  in  1; TX_FULL  out  1: local load of the bus-readable holding register.

Function
REQ-015 Register map: 0 DATA, 1 STATUS, 2 CTRL, 3 SCRATCH.
REQ-016 ADDR and DBUS_IN captured every cycle any selected WRxN is low; write commits the cycle after the last asserted WRxN is seen high again.
REQ-017 Byte-lane enables for a commit = union of WR0N and WR1N seen low during the strobe; strobes released in different cycles commit once, on the later release.
REQ-018 DATA write with lane 0 enabled pushes the merged word (unwritten lane = 0) into the FIFO; high-lane-only DATA write is ignored.
REQ-019 DATA push when FIFO full and no same-cycle local pop: word dropped, STATUS.OVF set (sticky).
REQ-020 DATA push when full with same-cycle RX_VALID & RX_READY pop: push accepted, count unchanged.
REQ-021 RX_VALID = FIFO not empty; RX_DATA = head entry; pop when RX_VALID & RX_READY; FIFO order preserved.
REQ-022 STATUS read: [0] TX_FULL, [1] FIFO full, [2] OVF, [7:4] FIFO count, others 0; write with bit2 = 1 clears OVF; other bits read-only.
REQ-023 CTRL: [0] TXIE, [1] OVFIE, byte-lane writable, others 0; SCRATCH: 16-bit byte-lane read/write.
REQ-024 DBUS_OE and DBUS_OUT registered: asserted with read data the cycle after selected RDN low is sampled; deasserted the cycle after RDN high is sampled.
REQ-025 DATA read returns holding register (0 when TX_FULL = 0); holding register emptied the cycle after RDN release.
REQ-026 TX_LOAD while TX_FULL = 1 ignored, unless the same cycle is a bus DATA-read release: then load wins, TX_FULL stays 1 with new data.
REQ-027 RDN low together with any WRxN low: write proceeds, DBUS_OE stays 0, no read side effects.
REQ-028 Unselected addresses: no commit, no read side effect, DBUS_OE 0.

Reset
REQ-029 RESET clears FIFO, holding register, TX_FULL, OVF, CTRL, SCRATCH, DBUS_OUT, DBUS_OE, INT, and the strobe-history registers (held as released).
REQ-030 Reset mid-strobe abandons the access; the strobe release after reset produces no commit and no pop.

Configuration
REQ-031 Macro EXT_BUS_TARGET_IRQ_EN defined: INT registered, = (TXIE & TX_FULL) | (OVFIE & OVF), one-cycle latency.
REQ-032 Macro EXT_BUS_TARGET_IRQ_EN undefined: INT tied 0; CTRL reads 0; CTRL writes ignored.

Structure
REQ-033 Package ext_bus_pkg holds register offsets, STATUS/CTRL bit positions, and default BASE_ADDR.
REQ-034 FIFO implemented as sub-module ext_bus_fifo (push/pop/count/full/empty, FIFO_DEPTH parameter); decode, strobe tracking, and registers stay in ext_bus_target.

Verification
REQ-035 Write 16'hA55A to SCRATCH (both strobes), read back -> DBUS_OUT = 16'hA55A, DBUS_OE high one cycle after RDN low.
REQ-036 WR1N-only write 16'h12xx to SCRATCH holding 16'hA55A -> reads 16'h125A.
REQ-037 Five DATA writes 1..5 with RX_READY = 0, depth 4 -> STATUS = 16'h0046 (count 4, full, OVF); drain yields 1,2,3,4; STATUS write 16'h0004 clears OVF.
REQ-038 TX_LOAD 16'hBEEF, CTRL = 1 (IRQ_EN build) -> INT high; bus DATA read returns 16'hBEEF; INT and TX_FULL low the cycle after RDN release.
REQ-039 RESET asserted while WR0N low on DATA, WR0N released after reset -> FIFO stays empty, RX_VALID 0.
REQ-040 Access at BASE_ADDR + 4 -> no register change, DBUS_OE stays 0.

Source files
------------

// File: rtl/ext_bus_pkg.sv
// Shared definitions for the external-bus target: register offsets, STATUS/CTRL
// bit positions, default decode base and the strobe-tracking state encoding.
package ext_bus_pkg;

  localparam logic [15:0] DEFAULT_BASE_ADDR = 16'hFF00;

  localparam logic [1:0] REG_DATA    = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_CTRL    = 2'd2;
  localparam logic [1:0] REG_SCRATCH = 2'd3;

  localparam int unsigned ST_TX_FULL   = 0;
  localparam int unsigned ST_FIFO_FULL = 1;
  localparam int unsigned ST_OVF       = 2;
  localparam int unsigned ST_CNT_LSB   = 4;

  localparam int unsigned CTRL_TXIE  = 0;
  localparam int unsigned CTRL_OVFIE = 1;

  typedef enum logic [1:0] {
    S_SYNC,
    S_IDLE,
    S_WRITE,
    S_READ
  } bus_state_t;

  // Unwritten byte lanes read as zero in the committed word.
  function automatic logic [15:0] lane_merge(input logic [15:0] d, input logic [1:0] lanes);
    return {lanes[1] ? d[15:8] : 8'h00, lanes[0] ? d[7:0] : 8'h00};
  endfunction

endpackage

// File: rtl/ext_bus_target_if.sv
// Bus-side and local-side signal bundle of ext_bus_target.
// master = host/local logic driving the target, slave = the target itself.
interface ext_bus_target_if;
  logic [15:0] ADDR;
  logic        RDN;
  logic        WR0N;
  logic        WR1N;
  logic [15:0] DBUS_IN;
  logic [15:0] DBUS_OUT;
  logic        DBUS_OE;
  logic        INT;
  logic [15:0] RX_DATA;
  logic        RX_VALID;
  logic        RX_READY;
  logic [15:0] TX_DATA;
  logic        TX_LOAD;
  logic        TX_FULL;

  modport master (
    output ADDR, RDN, WR0N, WR1N, DBUS_IN, RX_READY, TX_DATA, TX_LOAD,
    input  DBUS_OUT, DBUS_OE, INT, RX_DATA, RX_VALID, TX_FULL
  );

  modport slave (
    input  ADDR, RDN, WR0N, WR1N, DBUS_IN, RX_READY, TX_DATA, TX_LOAD,
    output DBUS_OUT, DBUS_OE, INT, RX_DATA, RX_VALID, TX_FULL
  );
endinterface

// File: rtl/ext_bus_fifo.sv
// Synchronous bus-to-local FIFO; DEPTH must be a power of two (2..16).
// A push while full is accepted only when a pop happens in the same cycle.
module ext_bus_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [4:0]       count,
  output logic             full,
  output logic             empty
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [AW:0]      cnt_q;
  logic             push_ok, pop_ok;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == DEPTH_CNT);
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign dout    = mem[rptr_q];
  assign count   = 5'(cnt_q);

  always_ff @(posedge CLK) begin
    if (push_ok) mem[wptr_q] <= din;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + AW'(1);
      if (pop_ok)  rptr_q <= rptr_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end
endmodule

// File: rtl/ext_bus_target.sv
// Asynchronous-strobe bus target: DATA/STATUS/CTRL/SCRATCH registers, bus-to-local
// FIFO and a local-to-bus holding register. EXT_BUS_TARGET_IRQ_EN enables CTRL and INT.
module ext_bus_target
  import ext_bus_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR  = DEFAULT_BASE_ADDR,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input logic             CLK,
  input logic             RESET,
  ext_bus_target_if.slave bus
);

  bus_state_t  state_q, state_d;
  logic        sel, wr_low, rd_low;
  logic        cap_en, commit, rd_start, rd_release, oe_d;
  logic [1:0]  lanes_q, cap_off_q, rd_off_q, rd_off;
  logic [15:0] cap_data_q, wdata, rdata, status_word, ctrl_word;
  logic [15:0] scratch_q, hold_q, dout_q;
  logic        oe_q, tx_full_q, ovf_q;
  logic        fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [4:0]  fifo_count;
  logic [3:0]  cnt4;
  logic [15:0] fifo_dout;
  logic        data_rd_rel;

  assign sel    = (bus.ADDR[15:2] == BASE_ADDR[15:2]);
  assign wr_low = ~bus.WR0N | ~bus.WR1N;
  assign rd_low = ~bus.RDN;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state_q <= S_SYNC;
    else       state_q <= state_d;
  end

  // S_SYNC waits for every strobe to be released, so a strobe straddling reset
  // or a write overlapping a read never produces a commit or read side effect.
  always_comb begin
    state_d    = state_q;
    cap_en     = 1'b0;
    commit     = 1'b0;
    rd_start   = 1'b0;
    rd_release = 1'b0;
    oe_d       = 1'b0;
    case (state_q)
      S_SYNC: begin
        if (!rd_low && !wr_low) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (sel && wr_low) begin
          state_d = S_WRITE;
          cap_en  = 1'b1;
        end else if (sel && rd_low) begin
          state_d  = S_READ;
          rd_start = 1'b1;
          oe_d     = 1'b1;
        end
      end
      S_WRITE: begin
        if (wr_low) begin
          cap_en = sel;
        end else begin
          commit  = 1'b1;
          state_d = rd_low ? S_SYNC : S_IDLE;
        end
      end
      S_READ: begin
        if (wr_low) begin
          state_d = sel ? S_WRITE : S_SYNC;
          cap_en  = sel;
        end else if (!rd_low) begin
          rd_release = 1'b1;
          state_d    = S_IDLE;
        end else begin
          oe_d = 1'b1;
        end
      end
      default: state_d = S_SYNC;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      lanes_q    <= '0;
      cap_off_q  <= '0;
      cap_data_q <= '0;
      rd_off_q   <= '0;
    end else begin
      if (cap_en) begin
        lanes_q    <= (state_q == S_WRITE ? lanes_q : 2'b00) | {~bus.WR1N, ~bus.WR0N};
        cap_off_q  <= bus.ADDR[1:0];
        cap_data_q <= bus.DBUS_IN;
      end
      if (rd_start) rd_off_q <= bus.ADDR[1:0];
    end
  end

  assign wdata       = lane_merge(cap_data_q, lanes_q);
  assign fifo_push   = commit && (cap_off_q == REG_DATA) && lanes_q[0];
  assign fifo_pop    = ~fifo_empty & bus.RX_READY;
  assign data_rd_rel = rd_release && (rd_off_q == REG_DATA);

  ext_bus_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (16)
  ) u_fifo (
    .CLK   (CLK),
    .RESET (RESET),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (wdata),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      ovf_q     <= 1'b0;
      scratch_q <= '0;
      hold_q    <= '0;
      tx_full_q <= 1'b0;
    end else begin
      if (fifo_push && fifo_full && !fifo_pop)
        ovf_q <= 1'b1;
      else if (commit && (cap_off_q == REG_STATUS) && lanes_q[0] && cap_data_q[ST_OVF])
        ovf_q <= 1'b0;
      if (commit && (cap_off_q == REG_SCRATCH)) begin
        if (lanes_q[0]) scratch_q[7:0]  <= cap_data_q[7:0];
        if (lanes_q[1]) scratch_q[15:8] <= cap_data_q[15:8];
      end
      if (bus.TX_LOAD && (!tx_full_q || data_rd_rel)) begin
        hold_q    <= bus.TX_DATA;
        tx_full_q <= 1'b1;
      end else if (data_rd_rel) begin
        hold_q    <= '0;
        tx_full_q <= 1'b0;
      end
    end
  end

`ifdef EXT_BUS_TARGET_IRQ_EN
  logic [1:0] ctrl_q;
  logic       int_q;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      ctrl_q <= '0;
      int_q  <= 1'b0;
    end else begin
      if (commit && (cap_off_q == REG_CTRL) && lanes_q[0]) ctrl_q <= cap_data_q[1:0];
      int_q <= (ctrl_q[CTRL_TXIE] & tx_full_q) | (ctrl_q[CTRL_OVFIE] & ovf_q);
    end
  end

  assign ctrl_word = {14'b0, ctrl_q};
  assign bus.INT   = int_q;
`else
  assign ctrl_word = '0;
  assign bus.INT   = 1'b0;
`endif

  // Count field is 4 bits wide; a full 16-deep FIFO reports 15 (FIFO full bit is exact).
  assign cnt4 = fifo_count[4] ? 4'hF : fifo_count[3:0];

  always_comb begin
    status_word                   = '0;
    status_word[ST_TX_FULL]       = tx_full_q;
    status_word[ST_FIFO_FULL]     = fifo_full;
    status_word[ST_OVF]           = ovf_q;
    status_word[ST_CNT_LSB +: 4]  = cnt4;
  end

  assign rd_off = rd_start ? bus.ADDR[1:0] : rd_off_q;

  always_comb begin
    rdata = '0;
    case (rd_off)
      REG_DATA:    rdata = tx_full_q ? hold_q : '0;
      REG_STATUS:  rdata = status_word;
      REG_CTRL:    rdata = ctrl_word;
      REG_SCRATCH: rdata = scratch_q;
      default:     rdata = '0;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      dout_q <= '0;
      oe_q   <= 1'b0;
    end else begin
      dout_q <= oe_d ? rdata : '0;
      oe_q   <= oe_d;
    end
  end

  assign bus.DBUS_OUT = dout_q;
  assign bus.DBUS_OE  = oe_q;
  assign bus.RX_DATA  = fifo_dout;
  assign bus.RX_VALID = ~fifo_empty;
  assign bus.TX_FULL  = tx_full_q;

endmodule

// File: tb/tb_ext_bus_target.sv
// Scoreboard bench for ext_bus_target: stimulus queues expected bus reads and
// FIFO pops; monitors compare when DBUS_OE rises or an RX handshake occurs.
module tb_ext_bus_target;
  logic clk = 1'b0;
  logic rst;

  ext_bus_target_if bus();

  ext_bus_target #(
    .BASE_ADDR  (16'hFF00),
    .FIFO_DEPTH (4)
  ) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int          checks   = 0;
  int          failures = 0;
  logic [15:0] rd_q[$];
  string       rd_name_q[$];
  logic [15:0] rx_q[$];
  logic        oe_prev  = 1'b0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.DBUS_OE === 1'b1 && !oe_prev) begin
      if (rd_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rd_unexpected: got %h expected no read", bus.DBUS_OUT);
      end else begin
        chk(rd_name_q.pop_front(), bus.DBUS_OUT, rd_q.pop_front());
      end
    end
    oe_prev = (bus.DBUS_OE === 1'b1);
    if (bus.RX_VALID === 1'b1 && bus.RX_READY === 1'b1) begin
      if (rx_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rx_unexpected: got %h expected no pop", bus.RX_DATA);
      end else begin
        chk("rx_pop", bus.RX_DATA, rx_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected TB_RESULT");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [15:0] addr, input logic [15:0] data, input logic [1:0] lanes);
    bus.ADDR = addr; bus.DBUS_IN = data;
    bus.WR0N = ~lanes[0]; bus.WR1N = ~lanes[1];
    tick();
    bus.WR0N = 1'b1; bus.WR1N = 1'b1;
    tick();
    tick();
  endtask

  // Full-FIFO write whose commit cycle coincides with one local pop.
  task automatic bus_write_pop(input logic [15:0] data);
    bus.ADDR = 16'hFF00; bus.DBUS_IN = data;
    bus.WR0N = 1'b0; bus.WR1N = 1'b0;
    tick();
    bus.WR0N = 1'b1; bus.WR1N = 1'b1; bus.RX_READY = 1'b1;
    tick();
    bus.RX_READY = 1'b0;
    tick();
  endtask

  task automatic bus_read(input string name, input logic [15:0] addr, input logic [15:0] exp,
                          input logic expect_oe, input logic ld, input logic [15:0] ld_data);
    if (expect_oe) begin
      rd_q.push_back(exp);
      rd_name_q.push_back(name);
    end
    bus.ADDR = addr; bus.RDN = 1'b0;
    tick();
    @(negedge clk);
    chk({name, "_oe"}, {15'b0, bus.DBUS_OE}, {15'b0, expect_oe});
    @(posedge clk); #1;
    bus.RDN = 1'b1;
    if (ld) begin bus.TX_LOAD = 1'b1; bus.TX_DATA = ld_data; end
    tick();
    bus.TX_LOAD = 1'b0;
    tick();
  endtask

  task automatic drain(input string name);
    bus.RX_READY = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!bus.RX_VALID) break;
    end
    chk({name, "_drained"}, {15'b0, bus.RX_VALID}, 16'h0000);
    bus.RX_READY = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic tx_load(input logic [15:0] d);
    bus.TX_DATA = d; bus.TX_LOAD = 1'b1;
    tick();
    bus.TX_LOAD = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.ADDR = 16'h0000; bus.RDN = 1'b1; bus.WR0N = 1'b1; bus.WR1N = 1'b1;
    bus.DBUS_IN = '0; bus.RX_READY = 1'b0; bus.TX_DATA = '0; bus.TX_LOAD = 1'b0;
    tick(); tick();
    @(negedge clk);
    chk("rst_oe",       {15'b0, bus.DBUS_OE},  16'h0000);
    chk("rst_dout",     bus.DBUS_OUT,          16'h0000);
    chk("rst_rx_valid", {15'b0, bus.RX_VALID}, 16'h0000);
    chk("rst_tx_full",  {15'b0, bus.TX_FULL},  16'h0000);
    chk("rst_int",      {15'b0, bus.INT},      16'h0000);
    rst = 1'b0;
    @(posedge clk); #1;
    tick();

    bus_write(16'hFF03, 16'hA55A, 2'b11);
    bus_read("scratch_a55a", 16'hFF03, 16'hA55A, 1'b1, 1'b0, '0);
    bus_write(16'hFF03, 16'h12FF, 2'b10);
    bus_read("scratch_hi_lane", 16'hFF03, 16'h125A, 1'b1, 1'b0, '0);
    bus_read("status_init", 16'hFF01, 16'h0000, 1'b1, 1'b0, '0);

    for (int i = 1; i <= 5; i++) bus_write(16'hFF00, 16'(i), 2'b11);
    bus_read("status_ovf", 16'hFF01, 16'h0046, 1'b1, 1'b0, '0);
    for (int i = 1; i <= 4; i++) rx_q.push_back(16'(i));
    drain("drain_1234");
    bus_read("status_ovf_empty", 16'hFF01, 16'h0004, 1'b1, 1'b0, '0);
    bus_write(16'hFF01, 16'h0004, 2'b11);
    bus_read("status_ovf_clr", 16'hFF01, 16'h0000, 1'b1, 1'b0, '0);

    bus_write(16'hFF00, 16'hAB00, 2'b10);
    bus_write(16'hFF00, 16'h12CD, 2'b01);
    bus.ADDR = 16'hFF00; bus.DBUS_IN = 16'h5678; bus.WR0N = 1'b0; bus.WR1N = 1'b0;
    tick();
    bus.WR1N = 1'b1;
    tick();
    bus.WR0N = 1'b1;
    tick(); tick();
    bus_read("status_cnt2", 16'hFF01, 16'h0020, 1'b1, 1'b0, '0);
    rx_q.push_back(16'h00CD);
    rx_q.push_back(16'h5678);
    drain("drain_lanes");

    for (int i = 0; i < 4; i++) bus_write(16'hFF00, 16'h0011 + 16'(i), 2'b11);
    rx_q.push_back(16'h0011);
    bus_write_pop(16'h0015);
    bus_read("status_full_pop", 16'hFF01, 16'h0042, 1'b1, 1'b0, '0);
    for (int i = 2; i <= 5; i++) rx_q.push_back(16'h0010 + 16'(i));
    drain("drain_full_pop");

    tx_load(16'hBEEF);
    @(negedge clk);
    chk("tx_full_set", {15'b0, bus.TX_FULL}, 16'h0001);
    @(posedge clk); #1;
`ifdef EXT_BUS_TARGET_IRQ_EN
    bus_write(16'hFF02, 16'h0001, 2'b11);
    @(negedge clk);
    chk("int_high", {15'b0, bus.INT}, 16'h0001);
    @(posedge clk); #1;
    bus_read("ctrl_rd", 16'hFF02, 16'h0001, 1'b1, 1'b0, '0);
`else
    bus_write(16'hFF02, 16'h0003, 2'b11);
    bus_read("ctrl_rd", 16'hFF02, 16'h0000, 1'b1, 1'b0, '0);
    @(negedge clk);
    chk("int_tied", {15'b0, bus.INT}, 16'h0000);
    @(posedge clk); #1;
`endif
    bus_read("data_beef", 16'hFF00, 16'hBEEF, 1'b1, 1'b0, '0);
    @(negedge clk);
    chk("tx_full_clr", {15'b0, bus.TX_FULL}, 16'h0000);
    chk("int_low",     {15'b0, bus.INT},     16'h0000);
    @(posedge clk); #1;
    bus_read("data_empty", 16'hFF00, 16'h0000, 1'b1, 1'b0, '0);

    tx_load(16'h1111);
    tx_load(16'h2222);
    bus_read("data_1111", 16'hFF00, 16'h1111, 1'b1, 1'b1, 16'h3333);
    @(negedge clk);
    chk("tx_full_reload", {15'b0, bus.TX_FULL}, 16'h0001);
    @(posedge clk); #1;

    bus.ADDR = 16'hFF00; bus.DBUS_IN = 16'h00A1;
    bus.RDN = 1'b0; bus.WR0N = 1'b0; bus.WR1N = 1'b0;
    tick();
    @(negedge clk);
    chk("rdwr_oe", {15'b0, bus.DBUS_OE}, 16'h0000);
    @(posedge clk); #1;
    bus.RDN = 1'b1; bus.WR0N = 1'b1; bus.WR1N = 1'b1;
    tick(); tick();
    @(negedge clk);
    chk("rdwr_tx_kept", {15'b0, bus.TX_FULL}, 16'h0001);
    @(posedge clk); #1;
    rx_q.push_back(16'h00A1);
    drain("drain_rdwr");
    bus_read("data_3333", 16'hFF00, 16'h3333, 1'b1, 1'b0, '0);

    bus_write(16'hFF04, 16'h7777, 2'b11);
    bus_read("unsel_rd", 16'hFF04, 16'h0000, 1'b0, 1'b0, '0);
    @(negedge clk);
    chk("unsel_rx_valid", {15'b0, bus.RX_VALID}, 16'h0000);
    @(posedge clk); #1;
    bus_read("unsel_status", 16'hFF01, 16'h0000, 1'b1, 1'b0, '0);
    bus_read("unsel_scratch", 16'hFF03, 16'h125A, 1'b1, 1'b0, '0);

    bus.ADDR = 16'hFF00; bus.DBUS_IN = 16'h0099; bus.WR0N = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick(); tick();
    bus.WR0N = 1'b1;
    tick(); tick();
    @(negedge clk);
    chk("midrst_rx_valid", {15'b0, bus.RX_VALID}, 16'h0000);
    @(posedge clk); #1;
    bus_read("midrst_status",  16'hFF01, 16'h0000, 1'b1, 1'b0, '0);
    bus_read("midrst_scratch", 16'hFF03, 16'h0000, 1'b1, 1'b0, '0);
    bus_write(16'hFF00, 16'h0042, 2'b11);
    rx_q.push_back(16'h0042);
    drain("drain_after_rst");

    tick(); tick();
    chk("rd_q_left", 16'(rd_q.size()), 16'h0000);
    chk("rx_q_left", 16'(rx_q.size()), 16'h0000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
